icache_refill: RTL and testbench

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/icache_refill_if.sv | 40 ++++
 rtl/icache_refill.sv | 106 ++++++++++
 tb/tb_icache_refill.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_if.sv
// L1 request/response and memory-bus read signals of the instruction-cache refill engine.
// The refill engine uses the slave modport; the L1/memory side uses the master modport.
interface icache_refill_if;
  logic         l1_mmu_req_read;
  logic [31:0]  l1_mmu_req_addr;
  logic         req_is_mmio;
  logic         mmu_l1_done;
  logic [255:0] mmu_l1_read_data;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         bus_err;

  modport slave (
    input  l1_mmu_req_read,
    input  l1_mmu_req_addr,
    input  req_is_mmio,
    output mmu_l1_done,
    output mmu_l1_read_data,
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output bus_err
  );

  modport master (
    output l1_mmu_req_read,
    output l1_mmu_req_addr,
    output req_is_mmio,
    input  mmu_l1_done,
    input  mmu_l1_read_data,
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  bus_err
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: 8-beat line fills or single-word MMIO reads,
// with stale-request detection and a per-beat acknowledge timeout.
module icache_refill #(
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic            sys_clk,
  input  logic            rst,
  icache_refill_if.slave  bus_io
);

  localparam int unsigned WaitW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StBurst, StDone, StHold, StDrain} state_e;

  state_e             state_q, state_d;
  logic [31:0]        base_q, base_d;
  logic               mmio_q, mmio_d;
  logic [2:0]         beat_q, beat_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               stale_q, stale_d;
  logic [255:0]       data_q, data_d;
  logic               stale_now;
  logic               last_beat;

  function automatic logic [31:0] line_base(input logic [31:0] addr, input logic mmio);
    return mmio ? (addr & 32'hFFFF_FFFC) : (addr & 32'hFFFF_FFE0);
  endfunction

  // Request withdrawn or moved to another line: finish the burst but drop the result.
  assign stale_now = !bus_io.l1_mmu_req_read ||
                     (line_base(bus_io.l1_mmu_req_addr, mmio_q) != base_q);
  assign last_beat = mmio_q ? (beat_q == 3'd0) : (beat_q == 3'd7);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    mmio_d  = mmio_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    stale_d = stale_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.l1_mmu_req_read) begin
          base_d  = line_base(bus_io.l1_mmu_req_addr, bus_io.req_is_mmio);
          mmio_d  = bus_io.req_is_mmio;
          beat_d  = 3'd0;
          wait_d  = '0;
          stale_d = 1'b0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        stale_d = stale_q | stale_now;
        if (bus_io.mem_ack) begin
          if (mmio_q) begin
            data_d = {224'd0, bus_io.mem_rdata};
          end else begin
            data_d[{beat_q, 5'd0} +: 32] = bus_io.mem_rdata;
          end
          beat_d = beat_q + 3'd1;
          wait_d = '0;
          if (last_beat) begin
            state_d = stale_d ? StIdle : StDone;
          end
        end else if (wait_q == WaitW'(ACK_TIMEOUT - 1)) begin
          wait_d  = '0;
          state_d = StDrain;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDone:  state_d = StHold;
      StHold:  state_d = StIdle;
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      mmio_q  <= 1'b0;
      beat_q  <= '0;
      wait_q  <= '0;
      stale_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mmio_q  <= mmio_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      stale_q <= stale_d;
      data_q  <= data_d;
    end
  end

  assign bus_io.mem_req          = (state_q == StBurst);
  assign bus_io.mem_addr         = bus_io.mem_req ? (base_q + {27'd0, beat_q, 2'b00}) : 32'd0;
  assign bus_io.mmu_l1_done      = (state_q == StDone);
  assign bus_io.bus_err          = (state_q == StDrain);
  assign bus_io.mmu_l1_read_data = data_q;

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: expected beat addresses and lines are queued at
// request time and checked as beats and done pulses appear on the bus.
module tb_icache_refill;
  localparam int unsigned AckTimeout = 15;

  logic sys_clk = 1'b0;
  logic rst;

  always #5 sys_clk = ~sys_clk;

  icache_refill_if bus ();

  icache_refill #(.ACK_TIMEOUT(AckTimeout)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus_io  (bus)
  );

  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  int           ack_cnt = 0;
  int           done_cnt = 0;
  int           err_cnt = 0;
  int           unack_run = 0;
  int           mode = 0;       // 0: zero-wait, 1: ack every 3rd cycle, 2: never ack
  int           wcnt = 0;
  logic         mmio_data = 1'b0;
  logic [31:0]  addr_q[$];
  logic [255:0] line_q[$];
  logic         prev_req = 1'b0;
  logic         prev_ack = 1'b0;
  logic [31:0]  prev_addr = '0;

  // Memory model: data is address-derived so line contents are predictable.
  assign bus.mem_ack   = bus.mem_req && (mode == 0 || (mode == 1 && wcnt == 2));
  assign bus.mem_rdata = mmio_data ? 32'hDEADBEEF : (bus.mem_addr ^ 32'h0000_0220);

  always @(posedge sys_clk) begin
    wcnt <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1 : 0;
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] exp_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = (base + 32'(4 * k)) ^ 32'h0000_0220;
    return l;
  endfunction

  task automatic push_burst(input logic [31:0] base, input int beats);
    for (int k = 0; k < beats; k++) addr_q.push_back(base + 32'(4 * k));
  endtask

  task automatic wait_acks(input int target, input string tag);
    int n = 0;
    while (ack_cnt < target && n < 500) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check_eq(tag, 256'(ack_cnt >= target), 256'd1);
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 500) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check_eq(tag, 256'(done_cnt >= target), 256'd1);
  endtask

  task automatic wait_err(input int target, input string tag);
    int n = 0;
    while (err_cnt < target && n < 500) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check_eq(tag, 256'(err_cnt >= target), 256'd1);
  endtask

  // Bus monitor, sampled on the inactive edge.
  always @(negedge sys_clk) begin
    if (!rst) begin
      if (prev_req && !prev_ack && bus.mem_req) check_eq("addr_stable", bus.mem_addr, prev_addr);
      if (!bus.mem_req) check_eq("addr_idle_zero", bus.mem_addr, 32'd0);
      if (bus.mem_req && bus.mem_ack) begin
        ack_cnt++;
        if (addr_q.size() == 0) check_eq("spurious_beat", bus.mem_addr, 256'hx);
        else check_eq("beat_addr", bus.mem_addr, addr_q.pop_front());
      end
      if (bus.mem_req && !bus.mem_ack) unack_run++;
      if (bus.bus_err) begin
        err_cnt++;
        check_eq("timeout_wait_cycles", 256'(unack_run), 256'(AckTimeout));
        check_eq("err_no_req", bus.mem_req, 1'b0);
        check_eq("err_no_done", bus.mmu_l1_done, 1'b0);
      end
      if (!bus.mem_req || bus.mem_ack) unack_run = 0;
      if (bus.mmu_l1_done) begin
        done_cnt++;
        if (line_q.size() == 0) check_eq("spurious_done", 256'd1, 256'd0);
        else check_eq("line_data", bus.mmu_l1_read_data, line_q.pop_front());
      end
      prev_req  = bus.mem_req;
      prev_ack  = bus.mem_ack;
      prev_addr = bus.mem_addr;
    end
  end

  initial begin
    int a0;
    int d0;
    rst = 1'b1;
    bus.l1_mmu_req_read = 1'b0;
    bus.l1_mmu_req_addr = '0;
    bus.req_is_mmio     = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("rst_mem_req", bus.mem_req, 1'b0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst_done", bus.mmu_l1_done, 1'b0);
    check_eq("rst_bus_err", bus.bus_err, 1'b0);
    check_eq("rst_data", bus.mmu_l1_read_data, 256'd0);
    rst = 1'b0;
    @(posedge sys_clk); #1;

    // Cached miss held high: latency, HOLD ignores request, re-accept in IDLE, then stale.
    push_burst(32'h0000_1220, 8);
    line_q.push_back(exp_line(32'h0000_1220));
    bus.l1_mmu_req_addr = 32'h0000_1234;
    bus.l1_mmu_req_read = 1'b1;
    repeat (9) @(posedge sys_clk);
    #1;
    check_eq("cached_latency_done", bus.mmu_l1_done, 1'b1);
    push_burst(32'h0000_1220, 8);
    @(posedge sys_clk); #1;
    check_eq("hold_no_req", bus.mem_req, 1'b0);
    check_eq("hold_done_low", bus.mmu_l1_done, 1'b0);
    @(posedge sys_clk); #1;
    check_eq("idle_no_req", bus.mem_req, 1'b0);
    @(posedge sys_clk); #1;
    check_eq("reaccept_req", bus.mem_req, 1'b1);
    bus.l1_mmu_req_read = 1'b0;
    wait_acks(16, "wait_rerun_beats");
    repeat (4) @(posedge sys_clk);
    #1;
    check_eq("rerun_stale_no_done", 256'(done_cnt), 256'd1);

    // MMIO single word.
    mmio_data = 1'b1;
    addr_q.push_back(32'hFFFF_FC60);
    line_q.push_back({224'd0, 32'hDEADBEEF});
    bus.l1_mmu_req_addr = 32'hFFFF_FC62;
    bus.req_is_mmio     = 1'b1;
    bus.l1_mmu_req_read = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check_eq("mmio_latency_done", bus.mmu_l1_done, 1'b1);
    @(posedge sys_clk); #1;
    bus.l1_mmu_req_read = 1'b0;
    bus.req_is_mmio     = 1'b0;
    mmio_data = 1'b0;
    repeat (2) @(posedge sys_clk);

    // Wait states.
    mode = 1;
    d0 = done_cnt;
    push_burst(32'h8000_00E0, 8);
    line_q.push_back(exp_line(32'h8000_00E0));
    bus.l1_mmu_req_addr = 32'h8000_00F6;
    bus.l1_mmu_req_read = 1'b1;
    wait_done(d0 + 1, "wait_ws_done");
    bus.l1_mmu_req_read = 1'b0;
    mode = 0;
    repeat (4) @(posedge sys_clk);
    #1;
    check_eq("ws_single_done", 256'(done_cnt), 256'(d0 + 1));

    // Stale: request dropped after beat 3.
    a0 = ack_cnt;
    d0 = done_cnt;
    push_burst(32'h0000_4000, 8);
    bus.l1_mmu_req_addr = 32'h0000_4010;
    bus.l1_mmu_req_read = 1'b1;
    wait_acks(a0 + 4, "wait_stale_4");
    bus.l1_mmu_req_read = 1'b0;
    wait_acks(a0 + 8, "wait_stale_8");
    repeat (4) @(posedge sys_clk);
    #1;
    check_eq("stale_no_done", 256'(done_cnt), 256'(d0));
    check_eq("stale_idle", bus.mem_req, 1'b0);

    // Timeout then retry from beat 0.
    mode = 2;
    d0 = done_cnt;
    push_burst(32'h0000_2040, 8);
    line_q.push_back(exp_line(32'h0000_2040));
    bus.l1_mmu_req_addr = 32'h0000_2044;
    bus.l1_mmu_req_read = 1'b1;
    wait_err(1, "wait_bus_err");
    mode = 0;
    wait_done(d0 + 1, "wait_retry_done");
    bus.l1_mmu_req_read = 1'b0;
    repeat (3) @(posedge sys_clk);

    // Reset mid-burst.
    a0 = ack_cnt;
    d0 = done_cnt;
    push_burst(32'h0000_3000, 8);
    bus.l1_mmu_req_addr = 32'h0000_3008;
    bus.l1_mmu_req_read = 1'b1;
    wait_acks(a0 + 5, "wait_rst_5");
    rst = 1'b1;
    bus.l1_mmu_req_read = 1'b0;
    @(posedge sys_clk); #1;
    check_eq("mid_rst_mem_req", bus.mem_req, 1'b0);
    check_eq("mid_rst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("mid_rst_done", bus.mmu_l1_done, 1'b0);
    check_eq("mid_rst_err", bus.bus_err, 1'b0);
    check_eq("mid_rst_data", bus.mmu_l1_read_data, 256'd0);
    addr_q.delete();
    line_q.delete();
    rst = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    check_eq("post_rst_no_done", 256'(done_cnt), 256'(d0));
    check_eq("post_rst_idle", bus.mem_req, 1'b0);
    check_eq("addr_q_drained", 256'(addr_q.size()), 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
